mod_mul_seq: RTL and testbench

Parametrised, bit-serial modular multiplier computing M = (y * z) mod n for WIDTH-bit operands. It is the next-generation multiply-mod engine under the RSA modular-exponentiation controller. It replaces the full-width product-then-divide approach with interleaved shift-add-reduce, so no 2*WIDTH-bit multiplier is needed. It adds a valid/ready handshake on both sides, pre-reduction of z, and a divide-by-zero error flag.

---
 rtl/mod_mul_pkg.sv | 24 ++
 rtl/mod_dbl_add_reduce.sv | 45 ++++
 rtl/mod_mul_seq.sv | 151 +++++++++++++++
 tb/tb_mod_mul_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_mul_pkg.sv
// Shared types and constants for the bit-serial modular multiplier.
// Holds the FSM state encoding and the bit-index counter width helper.
package mod_mul_pkg;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_REDZ = 2'd1;
  localparam logic [1:0] ENC_MUL  = 2'd2;
  localparam logic [1:0] ENC_DONE = 2'd3;

  // Largest number of conditional subtractions the reduce stage supports
  localparam int MAX_SUB_LIMIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_REDZ = ENC_REDZ,
    ST_MUL  = ENC_MUL,
    ST_DONE = ENC_DONE
  } state_t;

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mod_dbl_add_reduce.sv
// Combinational step (2*acc + addend) followed by up to MAX_SUB conditional
// subtractions of n. Assumes acc < n and addend < n so the result lands below n.
module mod_dbl_add_reduce
  import mod_mul_pkg::*;
#(
  parameter int WIDTH   = 256,
  parameter int MAX_SUB = 1
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_addend,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_res
);

  localparam int TW = WIDTH + 2;

  generate
    if (MAX_SUB < 1 || MAX_SUB > MAX_SUB_LIMIT) begin : g_bad_max_sub
      $error("mod_dbl_add_reduce: MAX_SUB must be 1 or 2");
    end
  endgenerate

  logic [TW-1:0] w_n_ext;
  logic [TW-1:0] w_t0;
  logic [TW-1:0] w_t1;
  logic [TW-1:0] w_t2;
  logic [1:0]    w_unused_hi;

  // Two guard bits: 2*acc + addend < 3n < 2^(WIDTH+2)
  assign w_n_ext = {2'b00, i_n};
  assign w_t0    = {1'b0, i_acc, 1'b0} + {2'b00, i_addend};
  assign w_t1    = (w_t0 >= w_n_ext) ? (w_t0 - w_n_ext) : w_t0;

  generate
    if (MAX_SUB == 2) begin : g_two_sub
      assign w_t2 = (w_t1 >= w_n_ext) ? (w_t1 - w_n_ext) : w_t1;
    end else begin : g_one_sub
      assign w_t2 = w_t1;
    end
  endgenerate

  assign o_res       = w_t2[WIDTH-1:0];
  assign w_unused_hi = w_t2[TW-1:WIDTH];

endmodule

// File: rtl/mod_mul_seq.sv
// Bit-serial modular multiplier M = (y*z) mod n: pre-reduces z over WIDTH
// cycles, then interleaves shift-add-reduce over the bits of y, MSB first.
module mod_mul_seq
  import mod_mul_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] M,
  output logic             err
);

  localparam int               CNT_W   = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("mod_mul_seq: WIDTH must be at least 2");
    end
  endgenerate

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_z;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_zr;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_m;
  logic             r_err;
  logic             r_out_valid;
  logic             r_in_ready;

  logic [WIDTH-1:0] w_z_bit;
  logic [WIDTH-1:0] w_mul_addend;
  logic [WIDTH-1:0] w_redz_res;
  logic [WIDTH-1:0] w_mul_res;
  logic             w_cnt_zero;

  assign w_z_bit      = {{(WIDTH-1){1'b0}}, r_z[r_cnt]};
  assign w_mul_addend = r_y[r_cnt] ? r_zr : '0;
  assign w_cnt_zero   = (r_cnt == '0);

  // z mod n, one bit of z per cycle; rem stays below n so one subtract suffices
  mod_dbl_add_reduce #(
    .WIDTH   (WIDTH),
    .MAX_SUB (1)
  ) u_redz (
    .i_acc    (r_rem),
    .i_addend (w_z_bit),
    .i_n      (r_n),
    .o_res    (w_redz_res)
  );

  // Horner step over y; 2*acc + zr < 3n so two subtracts suffice
  mod_dbl_add_reduce #(
    .WIDTH   (WIDTH),
    .MAX_SUB (2)
  ) u_mul (
    .i_acc    (r_acc),
    .i_addend (w_mul_addend),
    .i_n      (r_n),
    .o_res    (w_mul_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_n         <= '0;
      r_rem       <= '0;
      r_zr        <= '0;
      r_acc       <= '0;
      r_m         <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_y        <= y;
            r_z        <= z;
            r_n        <= n;
            r_in_ready <= 1'b0;
            if (n == '0) begin
              r_m         <= '0;
              r_err       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_rem   <= '0;
              r_cnt   <= CNT_MAX;
              r_state <= ST_REDZ;
            end
          end
        end
        ST_REDZ: begin
          r_rem <= w_redz_res;
          if (w_cnt_zero) begin
            r_zr    <= w_redz_res;
            r_acc   <= '0;
            r_cnt   <= CNT_MAX;
            r_state <= ST_MUL;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_MUL: begin
          r_acc <= w_mul_res;
          if (w_cnt_zero) begin
            r_m         <= w_mul_res;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          // M is left as-is after handoff; out_valid alone qualifies it
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign M         = r_m;
  assign err       = r_err;

endmodule

// File: tb/tb_mod_mul_seq.sv
// Scoreboard bench for mod_mul_seq at WIDTH=8: directed operand vectors with
// hand-computed results, backpressure, ignored in_valid, and mid-op reset.
module tb_mod_mul_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] y = '0;
  logic [W-1:0] z = '0;
  logic [W-1:0] n = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] M;
  logic         err;

  mod_mul_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .z         (z),
    .n         (n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .M         (M),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] m;
    logic         e;
    int           lat;
    int           acc_cyc;
    int           id;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic [W-1:0] n;
    logic [W-1:0] m;
    logic         e;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   op_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Monitor: checks latency when out_valid rises, result on handoff
  initial begin
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: out_valid with no pending op, M=%0d err=%0d", M, err);
          end else begin
            check($sformatf("latency op%0d", q[0].id), 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
          end
        end
        if (out_valid && out_ready && q.size() > 0) begin
          check($sformatf("M op%0d", q[0].id), 32'(M), 32'(q[0].m));
          check($sformatf("err op%0d", q[0].id), 32'(err), 32'(q[0].e));
          void'(q.pop_front());
        end
        prev_ov = out_valid;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic do_op(input logic [W-1:0] ty, input logic [W-1:0] tz, input logic [W-1:0] tn,
                       input logic [W-1:0] em, input logic ee);
    int waited;
    exp_t e;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready got 0 required 1 after %0d cycles", waited);
      return;
    end
    y = ty;
    z = tz;
    n = tn;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.m = em;
    e.e = ee;
    e.lat = (tn == '0) ? 0 : 2 * W;
    e.acc_cyc = cyc;
    e.id = op_id;
    q.push_back(e);
    op_id++;
    // Scramble operands: only the values at accept may matter
    y = W'($urandom);
    z = W'($urandom);
    n = W'($urandom);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((q.size() != 0 || out_valid) && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (q.size() != 0 || out_valid) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending=%0d out_valid=%0d required 0/0", q.size(), out_valid);
      q.delete();
    end
  endtask

  vec_t vecs[13];

  initial begin
    vecs = '{
      '{8'd200, 8'd100, 8'd251, 8'd171, 1'b0},
      '{8'd3,   8'd250, 8'd7,   8'd1,   1'b0},
      '{8'd255, 8'd255, 8'd255, 8'd0,   1'b0},
      '{8'd77,  8'd190, 8'd1,   8'd0,   1'b0},
      '{8'd5,   8'd9,   8'd0,   8'd0,   1'b1},
      '{8'd2,   8'd3,   8'd5,   8'd1,   1'b0},
      '{8'd0,   8'd77,  8'd13,  8'd0,   1'b0},
      '{8'd99,  8'd0,   8'd50,  8'd0,   1'b0},
      '{8'd13,  8'd11,  8'd17,  8'd7,   1'b0},
      '{8'd255, 8'd254, 8'd253, 8'd2,   1'b0},
      '{8'd128, 8'd128, 8'd200, 8'd184, 1'b0},
      '{8'd1,   8'd200, 8'd3,   8'd2,   1'b0},
      '{8'd255, 8'd255, 8'd254, 8'd1,   1'b0}
    };

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset M", 32'(M), 32'd0);
    check("reset err", 32'(err), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back directed operations
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].y, vecs[i].z, vecs[i].n, vecs[i].m, vecs[i].e);
    end
    wait_drain();

    // Backpressure: hold the result for 10 cycles while poking in_valid
    out_ready = 1'b0;
    do_op(8'd13, 8'd11, 8'd17, 8'd7, 1'b0);
    for (int w = 0; w < 40 && !out_valid; w++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      y = 8'd1;
      z = 8'd1;
      n = 8'd0;
      in_valid = (i % 2 == 0);
      @(negedge clk);
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp M", 32'(M), 32'd7);
      check("bp err", 32'(err), 32'd0);
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("handoff out_valid", 32'(out_valid), 32'd0);
    check("handoff in_ready", 32'(in_ready), 32'd1);
    wait_drain();

    // Reset in the middle of the multiply phase
    do_op(8'd200, 8'd100, 8'd251, 8'd171, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    @(negedge clk);
    check("rst_mid out_valid", 32'(out_valid), 32'd0);
    check("rst_mid M", 32'(M), 32'd0);
    check("rst_mid err", 32'(err), 32'd0);
    check("rst_mid in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    do_op(8'd2, 8'd3, 8'd5, 8'd1, 1'b0);
    do_op(8'd200, 8'd100, 8'd251, 8'd171, 1'b0);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
